// File: rtl/qcm_basis_pkg.sv
// Shared encodings for the basis-index list: command opcodes, gate codes and FSM states.
package qcm_basis_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_PUSH   = 3'd1,
        OP_POP    = 3'd2,
        OP_ROTATE = 3'd3,
        OP_SWEEP  = 3'd4,
        OP_CLEAR  = 3'd5
    } cmd_op_e;

    typedef enum logic [2:0] {
        GATE_H    = 3'd0,
        GATE_CNOT = 3'd2,
        GATE_X    = 3'd6,
        GATE_SWAP = 3'd7
    } gate_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/basis_gate_xform.sv
// Combinational action of a single gate on one computational-basis index.
module basis_gate_xform
    import qcm_basis_pkg::*;
#(
    parameter int NUM_QUBIT = 4,
    parameter int PW        = $clog2(NUM_QUBIT)
) (
    input  logic [NUM_QUBIT-1:0] idx_in,
    input  logic [2:0]           gate_type,
    input  logic [PW-1:0]        qubit_pos,
    input  logic [PW-1:0]        qubit_pos2,
    output logic [NUM_QUBIT-1:0] idx_out
);

    localparam logic [PW:0] NQ = (PW+1)'(NUM_QUBIT);

    logic pos_bad;

    assign pos_bad = ({1'b0, qubit_pos} >= NQ) || ({1'b0, qubit_pos2} >= NQ);

    always_comb begin
        idx_out = idx_in;
        if (!pos_bad) begin
            case (gate_type)
                GATE_H, GATE_X: idx_out[qubit_pos] = ~idx_in[qubit_pos];
                GATE_CNOT: begin
                    // Equal control and target degenerates to identity.
                    if (qubit_pos != qubit_pos2 && idx_in[qubit_pos])
                        idx_out[qubit_pos2] = ~idx_in[qubit_pos2];
                end
                GATE_SWAP: begin
                    idx_out[qubit_pos]  = idx_in[qubit_pos2];
                    idx_out[qubit_pos2] = idx_in[qubit_pos];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/basis_index_list.sv
// Circular list of basis indices with push/pop/rotate and a multi-cycle SWEEP that
// applies one gate to every stored entry while preserving order.
module basis_index_list
    import qcm_basis_pkg::*;
#(
    parameter int  NUM_QUBIT = 4,
    parameter int  DEPTH     = 2**NUM_QUBIT,
    localparam int PW        = $clog2(NUM_QUBIT),
    localparam int CW        = $clog2(DEPTH+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [2:0]           gate_type,
    input  logic [PW-1:0]        qubit_pos,
    input  logic [PW-1:0]        qubit_pos2,
    input  logic [NUM_QUBIT-1:0] push_data,
    output logic [NUM_QUBIT-1:0] head_data,
    output logic [NUM_QUBIT-1:0] head_update,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 sweep_done,
    output logic                 err
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH-1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [PW:0]    NQ       = (PW+1)'(NUM_QUBIT);

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    state_e                 state_q, state_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d, rem_q, rem_d;
    logic [2:0]             sw_gate_q, sw_gate_d;
    logic [PW-1:0]          sw_pos_q, sw_pos_d, sw_pos2_q, sw_pos2_d;
    logic                   err_q, err_d, done_q, done_d;
    logic [NUM_QUBIT-1:0]   mem_q [DEPTH];
    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [NUM_QUBIT-1:0]   mem_wdata;
    logic [NUM_QUBIT-1:0]   sweep_update;
    logic                   accept, pos_bad;

    assign busy       = (state_q == ST_SWEEP);
    assign cmd_ready  = !busy;
    assign count      = count_q;
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign err        = err_q;
    assign sweep_done = done_q;
    assign head_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign accept     = cmd_valid && cmd_ready;
    assign pos_bad    = ({1'b0, qubit_pos} >= NQ) || ({1'b0, qubit_pos2} >= NQ);

    basis_gate_xform #(.NUM_QUBIT(NUM_QUBIT), .PW(PW)) u_head_xform (
        .idx_in     (head_data),
        .gate_type  (gate_type),
        .qubit_pos  (qubit_pos),
        .qubit_pos2 (qubit_pos2),
        .idx_out    (head_update)
    );

    basis_gate_xform #(.NUM_QUBIT(NUM_QUBIT), .PW(PW)) u_sweep_xform (
        .idx_in     (head_data),
        .gate_type  (sw_gate_q),
        .qubit_pos  (sw_pos_q),
        .qubit_pos2 (sw_pos2_q),
        .idx_out    (sweep_update)
    );

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        rem_d     = rem_q;
        sw_gate_d = sw_gate_q;
        sw_pos_d  = sw_pos_q;
        sw_pos2_d = sw_pos2_q;
        err_d     = 1'b0;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        mem_wdata = push_data;

        if (state_q == ST_SWEEP) begin
            // Each sweep step is a rotate using the gate captured at acceptance.
            mem_we    = 1'b1;
            mem_wdata = sweep_update;
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            wr_ptr_d  = ptr_inc(wr_ptr_q);
            rem_d     = rem_q - 1'b1;
            if (rem_q == CW'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (accept) begin
            case (cmd_op)
                OP_PUSH: begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        count_d  = count_q + 1'b1;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                        count_d  = count_q - 1'b1;
                    end
                end
                OP_ROTATE: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        err_d     = pos_bad;
                        mem_we    = 1'b1;
                        mem_wdata = head_update;
                        rd_ptr_d  = ptr_inc(rd_ptr_q);
                        wr_ptr_d  = ptr_inc(wr_ptr_q);
                    end
                end
                OP_SWEEP: begin
                    err_d     = pos_bad;
                    sw_gate_d = gate_type;
                    sw_pos_d  = qubit_pos;
                    sw_pos2_d = qubit_pos2;
                    if (empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SWEEP;
                        rem_d   = count_q;
                    end
                end
                OP_CLEAR: begin
                    count_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rem_q     <= '0;
            sw_gate_q <= '0;
            sw_pos_q  <= '0;
            sw_pos2_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            sw_gate_q <= sw_gate_d;
            sw_pos_q  <= sw_pos_d;
            sw_pos2_q <= sw_pos2_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    // Entry storage is data only; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_basis_index_list.sv
// Directed bench for basis_index_list: a 4-qubit/6-deep list plus a 5-qubit list
// for out-of-range qubit positions.
module tb_basis_index_list;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0, gate_type = '0;
    logic [1:0] qubit_pos = '0, qubit_pos2 = '0;
    logic [3:0] push_data = '0, head_data, head_update;
    logic [2:0] count;
    logic       full, empty, busy, sweep_done, err;

    basis_index_list #(.NUM_QUBIT(4), .DEPTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .gate_type(gate_type), .qubit_pos(qubit_pos),
        .qubit_pos2(qubit_pos2), .push_data(push_data), .head_data(head_data),
        .head_update(head_update), .count(count), .full(full), .empty(empty),
        .busy(busy), .sweep_done(sweep_done), .err(err)
    );

    logic       c2_valid = 1'b0;
    logic       c2_ready;
    logic [2:0] c2_op = '0, c2_gate = '0;
    logic [2:0] c2_pos = '0, c2_pos2 = '0;
    logic [4:0] c2_data = '0, c2_head, c2_upd;
    logic [2:0] c2_count;
    logic       c2_full, c2_empty, c2_busy, c2_done, c2_err;

    basis_index_list #(.NUM_QUBIT(5), .DEPTH(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_op(c2_op), .gate_type(c2_gate), .qubit_pos(c2_pos),
        .qubit_pos2(c2_pos2), .push_data(c2_data), .head_data(c2_head),
        .head_update(c2_upd), .count(c2_count), .full(c2_full), .empty(c2_empty),
        .busy(c2_busy), .sweep_done(c2_done), .err(c2_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] g,
                          input logic [1:0] p, input logic [1:0] p2,
                          input logic [3:0] d);
        cmd_op = op; gate_type = g; qubit_pos = p; qubit_pos2 = p2; push_data = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [2:0] g;
        logic [1:0] p;
        logic [1:0] p2;
        logic [3:0] d;
        int         cnt;
        int         head;
        int         err;
    } vec_t;

    vec_t tbl[17];
    int   busy_cycles, done_pulses, done_seen;
    int   q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{3'd1, 3'd0, 2'd0, 2'd0, 4'd1, 1, 1, 0};
        tbl[1]  = '{3'd1, 3'd0, 2'd0, 2'd0, 4'd2, 2, 1, 0};
        tbl[2]  = '{3'd1, 3'd0, 2'd0, 2'd0, 4'd3, 3, 1, 0};
        tbl[3]  = '{3'd1, 3'd0, 2'd0, 2'd0, 4'd4, 4, 1, 0};
        tbl[4]  = '{3'd1, 3'd0, 2'd0, 2'd0, 4'd5, 5, 1, 0};
        tbl[5]  = '{3'd1, 3'd0, 2'd0, 2'd0, 4'd6, 6, 1, 0};
        tbl[6]  = '{3'd1, 3'd0, 2'd0, 2'd0, 4'd7, 6, 1, 1};   // push when full
        tbl[7]  = '{3'd2, 3'd0, 2'd0, 2'd0, 4'd0, 5, 2, 0};
        tbl[8]  = '{3'd3, 3'd6, 2'd1, 2'd0, 4'd0, 5, 3, 0};   // rotate X on 0010
        tbl[9]  = '{3'd5, 3'd0, 2'd0, 2'd0, 4'd0, 0, 0, 0};
        tbl[10] = '{3'd2, 3'd0, 2'd0, 2'd0, 4'd0, 0, 0, 1};   // pop when empty
        tbl[11] = '{3'd1, 3'd0, 2'd0, 2'd0, 4'd3, 1, 3, 0};
        tbl[12] = '{3'd3, 3'd2, 2'd0, 2'd3, 4'd0, 1, 11, 0};  // CNOT 0->3 on 0011
        tbl[13] = '{3'd3, 3'd2, 2'd0, 2'd0, 4'd0, 1, 11, 0};  // CNOT ctrl==tgt
        tbl[14] = '{3'd3, 3'd0, 2'd3, 2'd0, 4'd0, 1, 3, 0};   // H on bit 3
        tbl[15] = '{3'd2, 3'd0, 2'd0, 2'd0, 4'd0, 0, 0, 0};
        tbl[16] = '{3'd3, 3'd0, 2'd0, 2'd0, 4'd0, 0, 0, 1};   // rotate when empty

        repeat (3) @(posedge clk);
        #1;
        chk("rst count", count, 0);
        chk("rst empty", empty, 1);
        chk("rst busy", busy, 0);
        chk("rst head", head_data, 0);
        chk("rst err", err, 0);
        chk("rst done", sweep_done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle ready", cmd_ready, 1);

        for (int i = 0; i < 17; i++) begin
            do_cmd(tbl[i].op, tbl[i].g, tbl[i].p, tbl[i].p2, tbl[i].d);
            chk($sformatf("vec%0d count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d head", i), head_data, tbl[i].head);
            chk($sformatf("vec%0d err", i), err, tbl[i].err);
            chk($sformatf("vec%0d full", i), full, (tbl[i].cnt == 6) ? 1 : 0);
            chk($sformatf("vec%0d empty", i), empty, (tbl[i].cnt == 0) ? 1 : 0);
        end

        // Combinational head_update: SWAP bits 0 and 2 of 0001.
        do_cmd(3'd1, 3'd0, 2'd0, 2'd0, 4'd1);
        gate_type = 3'd7; qubit_pos = 2'd0; qubit_pos2 = 2'd2; #1;
        chk("swap head_update", head_update, 4);
        gate_type = 3'd1; #1;
        chk("identity code head_update", head_update, 1);
        @(posedge clk); #1;

        // Out-of-range position on the 5-qubit list.
        c2_op = 3'd1; c2_data = 5'd1; c2_valid = 1'b1;
        @(posedge clk); #1;
        c2_op = 3'd3; c2_gate = 3'd7; c2_pos = 3'd5; c2_pos2 = 3'd2; #1;
        chk("range head_update", c2_upd, 1);
        @(posedge clk); #1;
        c2_valid = 1'b0;
        chk("range err", c2_err, 1);
        chk("range head", c2_head, 1);
        chk("range count", c2_count, 1);
        @(posedge clk); #1;
        chk("range err clears", c2_err, 0);

        // Three-entry sweep with H on bit 0.
        do_cmd(3'd5, 3'd0, 2'd0, 2'd0, 4'd0);
        do_cmd(3'd1, 3'd0, 2'd0, 2'd0, 4'd1);
        do_cmd(3'd1, 3'd0, 2'd0, 2'd0, 4'd2);
        do_cmd(3'd1, 3'd0, 2'd0, 2'd0, 4'd3);
        do_cmd(3'd4, 3'd0, 2'd0, 2'd0, 4'd0);
        chk("sweep ready low", cmd_ready, 0);
        busy_cycles = 0; done_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            busy_cycles += busy;
            done_pulses += sweep_done;
            @(posedge clk); #1;
        end
        chk("sweep busy cycles", busy_cycles, 3);
        chk("sweep done pulses", done_pulses, 1);
        chk("sweep count", count, 3);
        chk("sweep entry0", head_data, 0);
        do_cmd(3'd2, 3'd0, 2'd0, 2'd0, 4'd0);
        chk("sweep entry1", head_data, 3);
        do_cmd(3'd2, 3'd0, 2'd0, 2'd0, 4'd0);
        chk("sweep entry2", head_data, 2);
        do_cmd(3'd2, 3'd0, 2'd0, 2'd0, 4'd0);

        // Pointer wrap: keep two entries in flight across 10 push/pop pairs.
        q.delete();
        do_cmd(3'd1, 3'd0, 2'd0, 2'd0, 4'd9);
        q.push_back(9);
        for (int i = 0; i < 10; i++) begin
            do_cmd(3'd1, 3'd0, 2'd0, 2'd0, 4'((i * 3 + 1) & 15));
            q.push_back((i * 3 + 1) & 15);
            chk($sformatf("wrap head%0d", i), head_data, q[0]);
            do_cmd(3'd2, 3'd0, 2'd0, 2'd0, 4'd0);
            void'(q.pop_front());
        end
        chk("wrap last head", head_data, q[0]);
        chk("wrap count", count, 1);
        do_cmd(3'd2, 3'd0, 2'd0, 2'd0, 4'd0);

        // Sweep on an empty list.
        do_cmd(3'd4, 3'd6, 2'd1, 2'd0, 4'd0);
        chk("empty sweep done", sweep_done, 1);
        chk("empty sweep busy", busy, 0);
        @(posedge clk); #1;
        chk("empty sweep done clears", sweep_done, 0);

        // Reset during cycle 2 of a five-entry sweep.
        for (int i = 0; i < 5; i++) do_cmd(3'd1, 3'd0, 2'd0, 2'd0, 4'(i + 1));
        do_cmd(3'd4, 3'd6, 2'd2, 2'd0, 4'd0);
        chk("pre-reset busy", busy, 1);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("mid-sweep reset count", count, 0);
        chk("mid-sweep reset busy", busy, 0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            done_seen += sweep_done;
            @(posedge clk); #1;
            if (i == 1) rst_n = 1'b1;
        end
        chk("no done after reset", done_seen, 0);
        chk("post-reset empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
